// File: rtl/tanh_lut_scheduler_pkg.sv
// Shared types and helpers for the tanh LUT scheduler: FSM encoding,
// default widths and the signed saturation used on the interpolated result.
package tanh_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        INTERP = 2'd2,
        OUT    = 2'd3
    } state_e;

    localparam int LUT_AW = 4;
    localparam int FRAC_W = 4;
    localparam int Y_W    = 8;
    localparam int SUM_W  = Y_W + FRAC_W + 2;

    // Clamp a wide signed value into the Y_W signed range.
    function automatic logic signed [Y_W-1:0] sat_signed(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = $signed({{(SUM_W-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}});
        lo = ~hi;
        if (v > hi) begin
            return hi[Y_W-1:0];
        end else if (v < lo) begin
            return lo[Y_W-1:0];
        end else begin
            return v[Y_W-1:0];
        end
    endfunction

endpackage

// File: rtl/tanh_lut_scheduler_arb.sv
// Round-robin arbiter: grants the first valid requester at or after ptr,
// wrapping, and reports the granted index alongside the one-hot grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 4
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic found_s;

    // Rotating priority search starting at ptr.
    always_comb begin
        gnt     = {NREQ{1'b0}};
        idx     = {IDW{1'b0}};
        found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NREQ;
            if (en && !found_s && valid[j]) begin
                gnt[j]  = 1'b1;
                idx     = j[IDW-1:0];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/tanh_lut_scheduler.sv
// Time-shares one tanh piecewise-linear LUT among NREQ requesters: arbitrate,
// look up base/next samples, interpolate on the fraction bits, return tagged result.
module tanh_lut_scheduler
    import tanh_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 4,
    parameter int XW   = 8,
    parameter int AW   = LUT_AW,
    parameter int FW   = FRAC_W,
    parameter int YW   = Y_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*XW-1:0]     req_x,
    output logic [NREQ-1:0]        req_ready,
    output logic [AW-1:0]          lut_addr,
    input  logic signed [YW-1:0]   lut_base,
    input  logic signed [YW-1:0]   lut_next,
    output logic                   res_valid,
    output logic signed [YW-1:0]   res_y,
    output logic [IDW-1:0]         res_id,
    input  logic                   res_ready,
    output logic                   busy
);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [IDW-1:0]         rr_ptr_r;
    logic [XW-1:0]          x_r;
    logic signed [YW-1:0]   base_r;
    logic signed [YW-1:0]   next_r;
    logic signed [YW-1:0]   res_y_r;
    logic [IDW-1:0]         res_id_r;
    logic                   res_valid_r;
    logic                   busy_r;

    logic [NREQ-1:0]        gnt_s;
    logic [IDW-1:0]         gnt_idx_s;
    logic                   arb_en_s;
    logic [XW-1:0]          sel_x_s;

    logic signed [YW:0]     diff_s;
    logic signed [YW+FW:0]  diff_ext_s;
    logic signed [YW+FW:0]  frac_ext_s;
    logic signed [YW+FW:0]  prod_s;
    logic signed [YW+FW:0]  shr_s;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [YW-1:0]   y_sat_s;

    // Grants are only possible in IDLE; reset also masks the combinational strobe.
    assign arb_en_s = (state_r == IDLE) && rst_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr_r),
        .en    (arb_en_s),
        .gnt   (gnt_s),
        .idx   (gnt_idx_s)
    );

    assign req_ready = gnt_s;
    assign lut_addr  = x_r[XW-1:FW];
    assign res_valid = res_valid_r;
    assign res_y     = res_y_r;
    assign res_id    = res_id_r;
    assign busy      = busy_r;

    // Operand mux for the granted requester.
    always_comb begin
        sel_x_s = req_x[int'(gnt_idx_s)*XW +: XW];
    end

    // Linear interpolation: base + floor((next-base)*frac / 2^FW), then saturate.
    always_comb begin
        diff_s     = $signed({next_r[YW-1], next_r}) - $signed({base_r[YW-1], base_r});
        diff_ext_s = $signed({{FW{diff_s[YW]}}, diff_s});
        frac_ext_s = $signed({{(YW+1){1'b0}}, x_r[FW-1:0]});
        prod_s     = diff_ext_s * frac_ext_s;
        shr_s      = prod_s >>> FW;
        sum_s      = $signed({{(FW+2){base_r[YW-1]}}, base_r}) + $signed({shr_s[YW+FW], shr_s});
        y_sat_s    = sat_signed(sum_s);
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (|gnt_s) begin
                    state_nxt_s = LOOKUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOOKUP: state_nxt_s = INTERP;
            INTERP: state_nxt_s = OUT;
            OUT: begin
                if (res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control registers; res_valid and busy are registered off the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            res_valid_r <= (state_nxt_s == OUT);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    // Datapath registers: capture on grant, sample LUT, latch result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {IDW{1'b0}};
            x_r      <= {XW{1'b0}};
            base_r   <= {YW{1'b0}};
            next_r   <= {YW{1'b0}};
            res_y_r  <= {YW{1'b0}};
            res_id_r <= {IDW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (|gnt_s) begin
                        x_r      <= sel_x_s;
                        res_id_r <= gnt_idx_s;
                        if (gnt_idx_s == IDW'(NREQ-1)) begin
                            rr_ptr_r <= {IDW{1'b0}};
                        end else begin
                            rr_ptr_r <= gnt_idx_s + {{(IDW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        rr_ptr_r <= rr_ptr_r;
                    end
                end
                LOOKUP: begin
                    base_r <= lut_base;
                    next_r <= lut_next;
                end
                INTERP: res_y_r <= y_sat_s;
                OUT: res_y_r <= res_y_r;
                default: res_y_r <= res_y_r;
            endcase
        end
    end

endmodule

// File: tb/tb_tanh_lut_scheduler.sv
// Scoreboard bench: stimulus queues expected results at grant time from a
// behavioural model; a negedge monitor compares grants and results.
module tb_tanh_lut_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 4;
    localparam int XW   = 8;
    localparam int AW   = 4;
    localparam int FW   = 4;
    localparam int YW   = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*XW-1:0]    req_x;
    logic [NREQ-1:0]       req_ready;
    logic [AW-1:0]         lut_addr;
    logic signed [YW-1:0]  lut_base;
    logic signed [YW-1:0]  lut_next;
    logic                  res_valid;
    logic signed [YW-1:0]  res_y;
    logic [IDW-1:0]        res_id;
    logic                  res_ready;
    logic                  busy;

    tanh_lut_scheduler #(
        .NREQ(NREQ), .IDW(IDW), .XW(XW), .AW(AW), .FW(FW), .YW(YW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
        .req_ready(req_ready), .lut_addr(lut_addr), .lut_base(lut_base),
        .lut_next(lut_next), .res_valid(res_valid), .res_y(res_y),
        .res_id(res_id), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    logic signed [7:0] lut [16];

    // Shared LUT with saturation at address 7 and wrap at address 15.
    always_comb begin
        lut_base = lut[lut_addr];
        if (lut_addr == 4'd7) lut_next = lut[7];
        else if (lut_addr == 4'd15) lut_next = lut[0];
        else lut_next = lut[lut_addr + 4'd1];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_y(input int x);
        int a, f, b, n, p, q, y;
        a = x / 16;
        f = x % 16;
        b = lut[a];
        n = (a == 7) ? lut[7] : (a == 15) ? lut[0] : lut[a+1];
        p = (n - b) * f;
        q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        y = b + q;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Model and scoreboard state (written by the monitor only).
    int  m_ptr = 0;
    bit  in_flight = 1'b0;
    int  gcyc = 0;
    int  idle_cyc = 0;
    int  exp_id_q[$];
    int  exp_y_q[$];
    int  glog[$];
    int  gcyc_log[$];
    int  last_y = 0;
    int  last_id = 0;
    int  gnt_cnt[NREQ];

    // Monitor: grant prediction, latency, handshake, result compare.
    always @(negedge clk) begin
        int  j;
        int  ey, eid;
        bit  model_idle, exp_rv;
        if (!rst_n) begin
            m_ptr = 0; in_flight = 1'b0; idle_cyc = 0;
            exp_id_q.delete(); exp_y_q.delete();
            chk("reset_req_ready", int'(req_ready), 0);
            chk("reset_res_valid", int'(res_valid), 0);
            chk("reset_busy", int'(busy), 0);
        end else begin
            model_idle = !in_flight && (cyc >= idle_cyc);
            exp_rv = in_flight && (cyc - gcyc >= 3);
            chk("busy", int'(busy), int'(in_flight));
            chk("res_valid", int'(res_valid), int'(exp_rv));
            j = model_idle ? rr_pick(req_valid, m_ptr) : -1;
            chk("req_ready", int'(req_ready), (j >= 0) ? (1 << j) : 0);
            if (exp_rv && res_valid && res_ready) begin
                if (exp_y_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    ey = exp_y_q.pop_front();
                    eid = exp_id_q.pop_front();
                    chk("res_y", int'(res_y), ey);
                    chk("res_id", int'(res_id), eid);
                    last_y = int'(res_y);
                    last_id = int'(res_id);
                end
                in_flight = 1'b0;
                idle_cyc = cyc + 1;
            end
            if (j >= 0) begin
                exp_id_q.push_back(j);
                exp_y_q.push_back(model_y(int'(req_x[j*XW +: XW])));
                m_ptr = (j + 1) % NREQ;
                in_flight = 1'b1;
                gcyc = cyc;
                glog.push_back(j);
                gcyc_log.push_back(cyc);
                gnt_cnt[j]++;
            end
        end
    end

    // Driver state.
    logic [NREQ-1:0] pend_v = '0;
    logic [XW-1:0]   pend_x [NREQ];
    int              seen [NREQ];
    bit              hold_all = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_cnt[i] != seen[i]) begin
                seen[i] = gnt_cnt[i];
                if (!hold_all) pend_v[i] = 1'b0;
            end
            req_x[i*XW +: XW] = pend_x[i];
        end
        req_valid = pend_v;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 80 && !done; k++) begin
            step();
            if (pend_v == '0 && exp_y_q.size() == 0 && !in_flight) done = 1'b1;
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    logic [7:0] dir_x [7] = '{8'h10, 8'h08, 8'h18, 8'hE8, 8'h78, 8'hF8, 8'h88};
    int         dir_y [7] = '{12, 6, 13, -14, 15, -6, -15};
    int         ord   [5] = '{0, 1, 2, 3, 0};

    initial begin
        int n0, y0, id0;
        lut = '{8'sd0, 8'sd12, 8'sd15, 8'sd15, 8'sd15, 8'sd15, 8'sd15, 8'sd15,
                -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd12};
        for (int i = 0; i < NREQ; i++) begin pend_x[i] = '0; seen[i] = 0; gnt_cnt[i] = 0; end
        rst_n = 1'b1; req_valid = '0; req_x = '0; res_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 req_valid = '1;
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_lut_addr", int'(lut_addr), 0);
        chk("rst_res_y", int'(res_y), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // All requesters held high: rotation order and 4-cycle issue interval.
        res_ready = 1'b1; hold_all = 1'b1;
        for (int i = 0; i < NREQ; i++) pend_x[i] = 8'($urandom);
        pend_v = '1;
        for (int k = 0; k < 60 && glog.size() < 5; k++) step();
        pend_v = '0;
        step();
        hold_all = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", (glog.size() > i) ? glog[i] : -1, ord[i]);
            if (i > 0) chk("rr_spacing", (gcyc_log.size() > i) ? gcyc_log[i] - gcyc_log[i-1] : -1, 4);
        end
        wait_idle("rr");

        // Directed interpolation and address-boundary cases.
        for (int k = 0; k < 7; k++) begin
            pend_x[0] = dir_x[k]; pend_v[0] = 1'b1;
            wait_idle("directed");
            chk("directed_y", last_y, dir_y[k]);
            chk("directed_id", last_id, 0);
        end

        // Output backpressure with a second requester waiting.
        res_ready = 1'b0;
        pend_x[1] = 8'($urandom); pend_x[2] = 8'($urandom);
        pend_v[1] = 1'b1; pend_v[2] = 1'b1;
        for (int k = 0; k < 20 && !res_valid; k++) step();
        y0 = int'(res_y); id0 = int'(res_id);
        chk("bp_valid", int'(res_valid), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_res_valid", int'(res_valid), 1);
            chk("bp_res_y", int'(res_y), y0);
            chk("bp_res_id", int'(res_id), id0);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        res_ready = 1'b1;
        wait_idle("bp");
        chk("bp_second_id", last_id, 2);

        // Reset during INTERP: nothing stale, pending request re-granted from ptr 0.
        pend_x[3] = 8'h38; pend_v[3] = 1'b1;
        n0 = glog.size();
        for (int k = 0; k < 20 && glog.size() == n0; k++) step();
        step();
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        pend_v[3] = 1'b1; req_valid[3] = 1'b1;
        #1;
        chk("mid_rst_res_valid", int'(res_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_req_ready", int'(req_ready), 0);
        chk("mid_rst_lut_addr", int'(lut_addr), 0);
        chk("mid_rst_res_y", int'(res_y), 0);
        chk("mid_rst_res_id", int'(res_id), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle("mid_rst");
        chk("regrant_id", glog[glog.size()-1], 3);
        chk("regrant_res_id", last_id, 3);

        // Randomized traffic with random LUT contents, drops and backpressure.
        for (int a = 0; a < 16; a++) lut[a] = 8'($urandom);
        for (int c = 0; c < 800; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && $urandom_range(3, 0) == 0) begin
                    pend_x[i] = 8'($urandom); pend_v[i] = 1'b1;
                end else if (pend_v[i] && $urandom_range(15, 0) == 0) begin
                    pend_v[i] = 1'b0;
                end
            end
            res_ready = ($urandom_range(2, 0) != 0);
        end
        pend_v = '0; res_ready = 1'b1;
        wait_idle("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
